// File: rtl/atomrv_pipe_ctrl.sv
// Hazard, forwarding and flush control for the 5-stage atomRV pipeline.
// Shadows the destination info of in-flight EX/MEM instructions and drives forward selects, stalls and flush.
module atomrv_pipe_ctrl #(
   parameter int REG_ADRESS_WIDTH = 5,
   parameter int LOAD_LAT         = 0,
   parameter bit FWD_EN           = 1'b1,
   parameter int CNT_W            = 16
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        id_valid_i,
   input  logic [REG_ADRESS_WIDTH-1:0] id_rs1_i,
   input  logic [REG_ADRESS_WIDTH-1:0] id_rs2_i,
   input  logic                        id_rs1_use_i,
   input  logic                        id_rs2_use_i,
   input  logic [REG_ADRESS_WIDTH-1:0] id_rd_i,
   input  logic                        id_rwr_en_i,
   input  logic                        id_load_i,
   input  logic                        br_taken_i,
   output logic [1:0]                  fwd1_o,
   output logic [1:0]                  fwd2_o,
   output logic                        stall_o,
   output logic                        mem_stall_o,
   output logic                        flush_o,
   output logic [CNT_W-1:0]            stall_cnt_o
);

   localparam logic [3:0] LAT_TC = LOAD_LAT[3:0];

   typedef struct packed {
      logic                        valid;
      logic [REG_ADRESS_WIDTH-1:0] rd;
      logic                        rwr_en;
      logic                        load;
   } stage_t;

   // The regfile is write-through, so the WB shadow never affects a decision
   // and only the EX and MEM shadows are kept.
   stage_t           ex_q;
   stage_t           mem_q;
   stage_t           id_entry;
   logic [3:0]       lat_cnt;
   logic [1:0]       fwd1_q;
   logic [1:0]       fwd2_q;
   logic [1:0]       fwd1_d;
   logic [1:0]       fwd2_d;
   logic [CNT_W-1:0] stall_cnt_q;
   logic             m_ex1;
   logic             m_ex2;
   logic             m_mem1;
   logic             m_mem2;
   logic             mem_stall;
   logic             load_use;
   logic             raw_nf;
   logic             flush;
   logic             stall;
   logic             issue;

   function automatic logic match(input stage_t s, input logic [REG_ADRESS_WIDTH-1:0] rs,
                                  input logic rs_use);
      return s.valid & s.rwr_en & (s.rd != '0) & (s.rd == rs) & rs_use;
   endfunction

   always_comb begin
      id_entry  = '{valid: id_valid_i, rd: id_rd_i, rwr_en: id_rwr_en_i, load: id_load_i};
      m_ex1     = match(ex_q, id_rs1_i, id_rs1_use_i);
      m_ex2     = match(ex_q, id_rs2_i, id_rs2_use_i);
      m_mem1    = match(mem_q, id_rs1_i, id_rs1_use_i);
      m_mem2    = match(mem_q, id_rs2_i, id_rs2_use_i);
      mem_stall = mem_q.valid & mem_q.load & (lat_cnt != LAT_TC);
      load_use  = FWD_EN & ex_q.load & (m_ex1 | m_ex2);
      raw_nf    = !FWD_EN & (m_ex1 | m_ex2 | m_mem1 | m_mem2);
      flush     = br_taken_i & !mem_stall;
      stall     = mem_stall | (id_valid_i & (load_use | raw_nf) & !flush);
      issue     = id_valid_i & !stall & !flush;
      fwd1_d    = 2'b00;
      fwd2_d    = 2'b00;
      // Newest producer wins: EX (about to be MEM) before MEM (about to be WB).
      if (FWD_EN && issue) begin
         if (m_ex1)       fwd1_d = 2'b01;
         else if (m_mem1) fwd1_d = 2'b10;
         if (m_ex2)       fwd2_d = 2'b01;
         else if (m_mem2) fwd2_d = 2'b10;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ex_q        <= '0;
         mem_q       <= '0;
         lat_cnt     <= '0;
         fwd1_q      <= 2'b00;
         fwd2_q      <= 2'b00;
         stall_cnt_q <= '0;
      end else begin
         if (!mem_stall) begin
            mem_q   <= ex_q;
            ex_q    <= issue ? id_entry : '0;
            fwd1_q  <= fwd1_d;
            fwd2_q  <= fwd2_d;
            lat_cnt <= '0;
         end else begin
            lat_cnt <= lat_cnt + 4'd1;
         end
         if (stall && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign fwd1_o      = fwd1_q;
   assign fwd2_o      = fwd2_q;
   assign stall_o     = stall & !rst_i;
   assign mem_stall_o = mem_stall & !rst_i;
   assign flush_o     = flush & !rst_i;
   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_atomrv_pipe_ctrl.sv
// Directed bench for atomrv_pipe_ctrl: three instances cover default, LOAD_LAT=3 and
// no-forwarding/LOAD_LAT=15/3-bit-counter configurations from one shared stimulus.
module tb_atomrv_pipe_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       id_valid = 1'b0;
   logic [4:0] id_rs1 = '0;
   logic [4:0] id_rs2 = '0;
   logic       id_rs1_use = 1'b0;
   logic       id_rs2_use = 1'b0;
   logic [4:0] id_rd = '0;
   logic       id_rwr_en = 1'b0;
   logic       id_load = 1'b0;
   logic       br_taken = 1'b0;

   logic [1:0]  d_fwd1, d_fwd2, l_fwd1, l_fwd2, n_fwd1, n_fwd2;
   logic        d_stall, d_mstall, d_flush, l_stall, l_mstall, l_flush, n_stall, n_mstall, n_flush;
   logic [15:0] d_cnt, l_cnt;
   logic [2:0]  n_cnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   atomrv_pipe_ctrl #(.REG_ADRESS_WIDTH(5), .LOAD_LAT(0), .FWD_EN(1'b1), .CNT_W(16)) u_def (
      .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
      .id_rs1_use_i(id_rs1_use), .id_rs2_use_i(id_rs2_use), .id_rd_i(id_rd),
      .id_rwr_en_i(id_rwr_en), .id_load_i(id_load), .br_taken_i(br_taken),
      .fwd1_o(d_fwd1), .fwd2_o(d_fwd2), .stall_o(d_stall), .mem_stall_o(d_mstall),
      .flush_o(d_flush), .stall_cnt_o(d_cnt));

   atomrv_pipe_ctrl #(.REG_ADRESS_WIDTH(5), .LOAD_LAT(3), .FWD_EN(1'b1), .CNT_W(16)) u_lat (
      .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
      .id_rs1_use_i(id_rs1_use), .id_rs2_use_i(id_rs2_use), .id_rd_i(id_rd),
      .id_rwr_en_i(id_rwr_en), .id_load_i(id_load), .br_taken_i(br_taken),
      .fwd1_o(l_fwd1), .fwd2_o(l_fwd2), .stall_o(l_stall), .mem_stall_o(l_mstall),
      .flush_o(l_flush), .stall_cnt_o(l_cnt));

   atomrv_pipe_ctrl #(.REG_ADRESS_WIDTH(5), .LOAD_LAT(15), .FWD_EN(1'b0), .CNT_W(3)) u_nf (
      .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
      .id_rs1_use_i(id_rs1_use), .id_rs2_use_i(id_rs2_use), .id_rd_i(id_rd),
      .id_rwr_en_i(id_rwr_en), .id_load_i(id_load), .br_taken_i(br_taken),
      .fwd1_o(n_fwd1), .fwd2_o(n_fwd2), .stall_o(n_stall), .mem_stall_o(n_mstall),
      .flush_o(n_flush), .stall_cnt_o(n_cnt));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                         input logic u2, input logic [4:0] rd, input logic wr, input logic ld);
      id_valid = v;  id_rs1 = rs1; id_rs1_use = u1; id_rs2 = rs2; id_rs2_use = u2;
      id_rd = rd;    id_rwr_en = wr; id_load = ld;
   endtask

   task automatic idle();
      set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      idle();
      br_taken = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      // Reset state, including outputs held low while rst is high
      idle();
      tick();
      @(negedge clk);
      chk("rst_stall_during", {31'd0, d_stall}, 32'd0);
      chk("rst_flush_during", {31'd0, d_flush}, 32'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_fwd1", {30'd0, d_fwd1}, 32'd0);
      chk("rst_fwd2", {30'd0, d_fwd2}, 32'd0);
      chk("rst_cnt", {16'd0, d_cnt}, 32'd0);
      chk("rst_mstall", {31'd0, l_mstall}, 32'd0);

      // 1: ADD x5,x1,x2 then ADD x6,x5,x5 -> no stall, both selects 01
      do_reset();
      set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
      @(negedge clk);
      chk("t1_stall", {31'd0, d_stall}, 32'd0);
      tick();
      idle();
      @(negedge clk);
      chk("t1_fwd1", {30'd0, d_fwd1}, 32'd1);
      chk("t1_fwd2", {30'd0, d_fwd2}, 32'd1);

      // 2: LW x5 then ADD x7,x5,x0 -> one stall, then fwd1=10 fwd2=00
      do_reset();
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0);
      @(negedge clk);
      chk("t2_stall_1", {31'd0, d_stall}, 32'd1);
      tick();
      @(negedge clk);
      chk("t2_stall_2", {31'd0, d_stall}, 32'd0);
      chk("t2_bubble_fwd1", {30'd0, d_fwd1}, 32'd0);
      tick();
      idle();
      @(negedge clk);
      chk("t2_fwd1", {30'd0, d_fwd1}, 32'd2);
      chk("t2_fwd2", {30'd0, d_fwd2}, 32'd0);
      chk("t2_cnt", {16'd0, d_cnt}, 32'd1);

      // 3: LOAD_LAT=3, LW x8 -> mem stall for exactly 3 cycles, counter +3; LOAD_LAT=0 never mem-stalls
      do_reset();
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
      tick();
      idle();
      @(negedge clk);
      chk("t3_mstall_ex", {31'd0, l_mstall}, 32'd0);
      tick();
      @(negedge clk);
      chk("t3_mstall_c1", {31'd0, l_mstall}, 32'd1);
      chk("t3_stall_c1", {31'd0, l_stall}, 32'd1);
      chk("t3_def_no_mstall", {31'd0, d_mstall}, 32'd0);
      tick();
      @(negedge clk);
      chk("t3_mstall_c2", {31'd0, l_mstall}, 32'd1);
      tick();
      @(negedge clk);
      chk("t3_mstall_c3", {31'd0, l_mstall}, 32'd1);
      tick();
      @(negedge clk);
      chk("t3_mstall_done", {31'd0, l_mstall}, 32'd0);
      chk("t3_cnt", {16'd0, l_cnt}, 32'd3);

      // 4: branch taken while ID has a load-use hazard -> flush wins, EX gets a bubble
      do_reset();
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
      br_taken = 1'b1;
      @(negedge clk);
      chk("t4_flush", {31'd0, d_flush}, 32'd1);
      chk("t4_stall", {31'd0, d_stall}, 32'd0);
      tick();
      br_taken = 1'b0;
      set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
      @(negedge clk);
      chk("t4_after_stall", {31'd0, d_stall}, 32'd0);
      tick();
      idle();
      @(negedge clk);
      chk("t4_bubble_fwd1", {30'd0, d_fwd1}, 32'd0);
      chk("t4_cnt", {16'd0, d_cnt}, 32'd0);

      // 5: FWD_EN=0, ADD x3 then SUB x4,x3,x1 -> two stalls, selects stay 00
      do_reset();
      set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 5'd3, 1'b1, 5'd1, 1'b1, 5'd4, 1'b1, 1'b0);
      @(negedge clk);
      chk("t5_stall_1", {31'd0, n_stall}, 32'd1);
      tick();
      @(negedge clk);
      chk("t5_stall_2", {31'd0, n_stall}, 32'd1);
      tick();
      @(negedge clk);
      chk("t5_stall_3", {31'd0, n_stall}, 32'd0);
      tick();
      // LW x9 with no sources; LOAD_LAT=15 drives the 3-bit counter into saturation
      set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
      @(negedge clk);
      chk("t5_fwd1", {30'd0, n_fwd1}, 32'd0);
      chk("t5_cnt", {29'd0, n_cnt}, 32'd2);
      tick();
      idle();
      tick();
      repeat (14) tick();
      @(negedge clk);
      chk("t5_mstall_c15", {31'd0, n_mstall}, 32'd1);
      tick();
      @(negedge clk);
      chk("t5_mstall_end", {31'd0, n_mstall}, 32'd0);
      chk("t5_cnt_sat", {29'd0, n_cnt}, 32'd7);

      // 6: write to x0 then a reader of x0 -> no stall, no forward
      do_reset();
      set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1, 1'b0);
      @(negedge clk);
      chk("t6_stall", {31'd0, d_stall}, 32'd0);
      chk("t6_nf_stall", {31'd0, n_stall}, 32'd0);
      tick();
      idle();
      @(negedge clk);
      chk("t6_fwd1", {30'd0, d_fwd1}, 32'd0);
      chk("t6_fwd2", {30'd0, d_fwd2}, 32'd0);

      // 6b: reset in the middle of a mem stall
      do_reset();
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
      tick();
      idle();
      tick();
      @(negedge clk);
      chk("t6_pre_mstall", {31'd0, l_mstall}, 32'd1);
      rst = 1'b1;
      #1;
      chk("t6_rst_mstall", {31'd0, l_mstall}, 32'd0);
      chk("t6_rst_stall", {31'd0, l_stall}, 32'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t6_post_mstall", {31'd0, l_mstall}, 32'd0);
      chk("t6_post_stall", {31'd0, l_stall}, 32'd0);
      chk("t6_post_cnt", {16'd0, l_cnt}, 32'd0);
      chk("t6_post_fwd1", {30'd0, l_fwd1}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
